// File: rtl/hack_pkg.sv
// Shared constants for the Hack ALU arbiter: ALU control encodings and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hack_pkg;

  // Control word is {zx,nx,zy,ny,f,no}, MSB first
  localparam int CTRL_W = 6;

  localparam logic [CTRL_W-1:0] ALU_ADD    = 6'b000010;
  localparam logic [CTRL_W-1:0] ALU_SUB_XY = 6'b010011;
  localparam logic [CTRL_W-1:0] ALU_AND    = 6'b000000;
  localparam logic [CTRL_W-1:0] ALU_ONE    = 6'b111111;
  localparam logic [CTRL_W-1:0] ALU_NEG1   = 6'b111010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/hack_alu.sv
// Combinational Hack ALU: zero/invert each operand, add or AND, optional output invert.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module hack_alu #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             zx_i,
  input  logic             nx_i,
  input  logic             zy_i,
  input  logic             ny_i,
  input  logic             f_i,
  input  logic             no_i,
  output logic [WIDTH-1:0] out_o,
  output logic             zr_o,
  output logic             ng_o
);

  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic [WIDTH-1:0] fo;

  // Operand conditioning, function select (carry out of the adder is dropped), output invert
  always_comb begin
    xs = zx_i ? '0 : x_i;
    xs = nx_i ? ~xs : xs;
    ys = zy_i ? '0 : y_i;
    ys = ny_i ? ~ys : ys;
    fo = f_i ? (xs + ys) : (xs & ys);
    out_o = no_i ? ~fo : fo;
    zr_o  = (out_o == '0);
    ng_o  = out_o[WIDTH-1];
  end

endmodule

// File: rtl/hack_alu_arbiter.sv
// Round-robin arbiter sharing one Hack ALU among NREQ valid/ack requesters.
// Latency: ack high in the 2nd cycle after the capture edge; one op per 3 cycles.
// Backpressure: requesters hold req_valid/operands until acked; new requests wait for IDLE.
module hack_alu_arbiter
  import hack_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_x,
  input  logic [NREQ*WIDTH-1:0]    req_y,
  input  logic [NREQ*CTRL_W-1:0]   req_ctrl,
  output logic [NREQ-1:0]          resp_ack,
  output logic [WIDTH-1:0]         resp_out,
  output logic                     resp_zr,
  output logic                     resp_ng,
  output logic [IDW-1:0]           gnt_id,
  output logic                     busy
);

  arb_state_t        state_q;
  logic [IDW-1:0]    rr_ptr_q;
  logic [IDW-1:0]    rr_ptr_d;
  logic [IDW-1:0]    gnt_q;
  logic [IDW-1:0]    sel_d;
  logic              busy_q;
  logic [NREQ-1:0]   ack_q;
  logic [WIDTH-1:0]  out_q;
  logic              zr_q;
  logic              ng_q;
  logic [WIDTH-1:0]  x_q;
  logic [WIDTH-1:0]  y_q;
  logic [CTRL_W-1:0] ctrl_q;

  logic [WIDTH-1:0]  alu_out;
  logic              alu_zr;
  logic              alu_ng;

  // First set bit at or above ptr, wrapping to 0; result is don't-care when v is empty
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] ptr);
    logic [IDW-1:0] sel;
    logic           found;
    int             idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && v[idx[IDW-1:0]]) begin
        sel   = idx[IDW-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Winner selection and the pointer that makes the just-served requester lowest priority
  always_comb begin
    sel_d    = rr_pick(req_valid, rr_ptr_q);
    rr_ptr_d = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + IDW'(1);
  end

  // The ALU only ever sees captured operands, so requesters may change inputs after capture
  hack_alu #(.WIDTH(WIDTH)) u_alu (
    .x_i  (x_q),
    .y_i  (y_q),
    .zx_i (ctrl_q[5]),
    .nx_i (ctrl_q[4]),
    .zy_i (ctrl_q[3]),
    .ny_i (ctrl_q[2]),
    .f_i  (ctrl_q[1]),
    .no_i (ctrl_q[0]),
    .out_o(alu_out),
    .zr_o (alu_zr),
    .ng_o (alu_ng)
  );

  // Arbiter FSM: IDLE captures a winner, EXEC registers the result, RESP carries the ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      ack_q    <= '0;
      out_q    <= '0;
      zr_q     <= 1'b0;
      ng_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      ctrl_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= '0;
          if (|req_valid) begin
            gnt_q   <= sel_d;
            x_q     <= req_x[sel_d*WIDTH +: WIDTH];
            y_q     <= req_y[sel_d*WIDTH +: WIDTH];
            ctrl_q  <= req_ctrl[sel_d*CTRL_W +: CTRL_W];
            busy_q  <= 1'b1;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          out_q   <= alu_out;
          zr_q    <= alu_zr;
          ng_q    <= alu_ng;
          ack_q   <= NREQ'(1) << gnt_q;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          ack_q    <= '0;
          rr_ptr_q <= rr_ptr_d;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign resp_ack = ack_q;
  assign resp_out = out_q;
  assign resp_zr  = zr_q;
  assign resp_ng  = ng_q;
  assign gnt_id   = gnt_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_hack_alu_arbiter.sv
// Self-checking bench for hack_alu_arbiter: directed vector table, corner sequences, random traffic.
// Latency: n/a.
// Backpressure: requesters hold valid until acked.
module tb_hack_alu_arbiter;
  import hack_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int IDW   = 2;

  logic                   clk;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*WIDTH-1:0]  req_x;
  logic [NREQ*WIDTH-1:0]  req_y;
  logic [NREQ*CTRL_W-1:0] req_ctrl;
  logic [NREQ-1:0]        resp_ack;
  logic [WIDTH-1:0]       resp_out;
  logic                   resp_zr;
  logic                   resp_ng;
  logic [IDW-1:0]         gnt_id;
  logic                   busy;

  int checks = 0;
  int errors = 0;

  hack_alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_x    (req_x),
    .req_y    (req_y),
    .req_ctrl (req_ctrl),
    .resp_ack (resp_ack),
    .resp_out (resp_out),
    .resp_zr  (resp_zr),
    .resp_ng  (resp_ng),
    .gnt_id   (gnt_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               req;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [5:0]       c;
    logic [WIDTH-1:0] eo;
    logic             ez;
    logic             en;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Hack ALU as arithmetic on unsigned integers: inversion is 2^W-1-v, add is mod 2^W
  function automatic logic [WIDTH-1:0] ref_alu(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic [5:0] c);
    int unsigned a, b, r, m;
    m = 65535;
    a = c[5] ? 0 : int'(x);
    if (c[4]) a = m - a;
    b = c[3] ? 0 : int'(y);
    if (c[2]) b = m - b;
    r = c[1] ? ((a + b) % 65536) : (a & b);
    if (c[0]) r = m - r;
    return r[WIDTH-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic [5:0] c);
    req_x[r*WIDTH +: WIDTH]    = x;
    req_y[r*WIDTH +: WIDTH]    = y;
    req_ctrl[r*CTRL_W +: CTRL_W] = c;
    req_valid[r] = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One isolated request starting in IDLE; checks capture, ack timing and result
  task automatic single_op(input vec_t v);
    set_req(v.req, v.x, v.y, v.c);
    tick();
    chk("single_gnt", 32'(gnt_id), 32'(v.req));
    chk("single_busy_exec", 32'(busy), 1);
    chk("single_noack_exec", 32'(resp_ack), 0);
    req_valid[v.req] = 1'b0;
    tick();
    chk("single_ack", 32'(resp_ack), 32'(1) << v.req);
    chk("single_out", 32'(resp_out), 32'(v.eo));
    chk("single_zr", 32'(resp_zr), 32'(v.ez));
    chk("single_ng", 32'(resp_ng), 32'(v.en));
    tick();
    chk("single_ack_clear", 32'(resp_ack), 0);
    chk("single_busy_clear", 32'(busy), 0);
  endtask

  initial begin
    logic [WIDTH-1:0] fx[NREQ];
    logic [WIDTH-1:0] fy[NREQ];
    int got, last_cyc;
    int free_edge, cap_edge, win, ptr;
    logic [WIDTH-1:0] m_out;
    logic [NREQ-1:0] exp_ack;

    tbl[0] = '{1, 16'd5, 16'd3, ALU_ADD,    16'd8,      1'b0, 1'b0};
    tbl[1] = '{0, 16'd3, 16'd5, ALU_SUB_XY, 16'hFFFE,   1'b0, 1'b1};
    tbl[2] = '{2, 16'd5, 16'd3, 6'b101010,  16'd0,      1'b1, 1'b0};
    tbl[3] = '{3, 16'd5, 16'd2, ALU_AND,    16'd0,      1'b1, 1'b0};
    tbl[4] = '{0, 16'h1234, 16'h0F0F, ALU_ONE,  16'd1,  1'b0, 1'b0};
    tbl[5] = '{1, 16'h00AA, 16'h5555, ALU_NEG1, 16'hFFFF, 1'b0, 1'b1};

    reset = 1'b1;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    req_ctrl = '0;
    #3;
    chk("rst_ack", 32'(resp_ack), 0);
    chk("rst_out", 32'(resp_out), 0);
    chk("rst_zr", 32'(resp_zr), 0);
    chk("rst_ng", 32'(resp_ng), 0);
    chk("rst_gnt", 32'(gnt_id), 0);
    chk("rst_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 6; i++) single_op(tbl[i]);

    // Fairness: all four requesters active from rr_ptr=0
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      fx[i] = WIDTH'(100 * i + 7);
      fy[i] = WIDTH'(i + 1);
      set_req(i, fx[i], fy[i], ALU_ADD);
    end
    got = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 20 && got < NREQ; cyc++) begin
      tick();
      if (resp_ack != '0) begin
        chk("fair_order", 32'(resp_ack), 32'(1) << got);
        chk("fair_out", 32'(resp_out), 32'(ref_alu(fx[got], fy[got], ALU_ADD)));
        if (got > 0) chk("fair_spacing", 32'(cyc - last_cyc), 3);
        last_cyc = cyc;
        for (int i = 0; i < NREQ; i++) if (resp_ack[i]) req_valid[i] = 1'b0;
        got++;
      end
    end
    chk("fair_count", 32'(got), NREQ);
    req_valid = '0;
    tick();

    // Pointer: after serving 2, requester 3 beats 0
    single_op('{2, 16'd1, 16'd1, ALU_ADD, 16'd2, 1'b0, 1'b0});
    set_req(0, 16'd4, 16'd4, ALU_ADD);
    set_req(3, 16'd9, 16'd1, ALU_ADD);
    tick();
    chk("rr_first_gnt", 32'(gnt_id), 3);
    tick();
    chk("rr_first_ack", 32'(resp_ack), 32'h8);
    chk("rr_first_out", 32'(resp_out), 10);
    req_valid[3] = 1'b0;
    tick();
    tick();
    chk("rr_second_gnt", 32'(gnt_id), 0);
    tick();
    chk("rr_second_ack", 32'(resp_ack), 32'h1);
    chk("rr_second_out", 32'(resp_out), 8);
    req_valid[0] = 1'b0;
    tick();

    // Reset during EXEC aborts the op; the held request is served again afterwards
    set_req(1, 16'd20, 16'd22, ALU_ADD);
    tick();
    chk("mid_busy_exec", 32'(busy), 1);
    chk("mid_gnt_exec", 32'(gnt_id), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ack", 32'(resp_ack), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_gnt", 32'(gnt_id), 0);
    tick();
    chk("mid_no_ack", 32'(resp_ack), 0);
    reset = 1'b0;
    tick();
    chk("mid_regnt", 32'(gnt_id), 1);
    chk("mid_regnt_busy", 32'(busy), 1);
    tick();
    chk("mid_ack", 32'(resp_ack), 32'h2);
    chk("mid_out", 32'(resp_out), 42);
    req_valid[1] = 1'b0;
    tick();

    // Random traffic against a transaction-level model
    do_reset();
    free_edge = 0;
    cap_edge  = -10;
    win       = 0;
    ptr       = 0;
    m_out     = '0;
    for (int kk = 0; kk < 800; kk++) begin
      tick();
      if (kk >= free_edge && req_valid != '0) begin
        for (int k = NREQ - 1; k >= 0; k--)
          if (req_valid[(ptr + k) % NREQ]) win = (ptr + k) % NREQ;
        m_out = ref_alu(req_x[win*WIDTH +: WIDTH], req_y[win*WIDTH +: WIDTH],
                        req_ctrl[win*CTRL_W +: CTRL_W]);
        cap_edge  = kk;
        free_edge = kk + 3;
        ptr       = (win + 1) % NREQ;
      end
      exp_ack = (kk == cap_edge + 1) ? NREQ'(1) << win : '0;
      chk("rnd_ack", 32'(resp_ack), 32'(exp_ack));
      chk("rnd_busy", 32'(busy), 32'(kk == cap_edge || kk == cap_edge + 1));
      if (kk == cap_edge) chk("rnd_gnt", 32'(gnt_id), 32'(win));
      if (exp_ack != '0) begin
        chk("rnd_out", 32'(resp_out), 32'(m_out));
        chk("rnd_zr", 32'(resp_zr), 32'(m_out == '0));
        chk("rnd_ng", 32'(resp_ng), 32'(m_out[WIDTH-1]));
      end
      for (int i = 0; i < NREQ; i++) begin
        if (exp_ack[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 3) == 0)
          set_req(i, WIDTH'($urandom), WIDTH'($urandom), 6'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
